// File: rtl/usb_disk_pkg.sv
// Shared definitions for the USB disk byte-port to word-bus bridge.
//   WORD_BYTES  - bytes per bus word
//   BLOCK_SIZE  - disk block size in bytes
//   DISK_ADDR_W - width of the byte-wide disk address
//   DISK_WORD_W - width of a disk word index (byte address without the lane bits)
//   bridge_state_t - bus-side FSM states
package usb_disk_pkg;

    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned BLOCK_SIZE  = 512;
    localparam int unsigned DISK_ADDR_W = 41;
    localparam int unsigned DISK_WORD_W = DISK_ADDR_W - 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_REQ  = 2'd1,
        RD_REQ  = 2'd2,
        RD_WAIT = 2'd3
    } bridge_state_t;

endpackage

// File: rtl/usb_disk_wpack.sv
// Write packer: collects disk bytes into a byte-enabled word buffer and hands
// finished (or stale) words to a single flush register for the bus FSM.
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   wr_en          - in-range write strobe for wr_byte at (wr_word, wr_lane)
//   wr_word        - disk word index of the write
//   wr_lane        - byte lane within the word
//   wr_byte        - write data byte
//   force_flush    - move a non-empty buffer to the flush register now
//   flush_done     - bus has accepted the flush register contents
//   wr_accept      - this cycle's write was merged or loaded (not dropped)
//   buf_busy       - write buffer holds at least one byte
//   flush_valid    - flush register occupied
//   flush_word     - word index of the flush register
//   flush_data     - flush register data
//   flush_be       - flush register byte enables
//   overflow_err   - sticky: a write byte was dropped
module usb_disk_wpack
    import usb_disk_pkg::*;
#(
    parameter int unsigned FLUSH_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [DISK_WORD_W-1:0] wr_word,
    input  logic [1:0]             wr_lane,
    input  logic [7:0]             wr_byte,
    input  logic                   force_flush,
    input  logic                   flush_done,
    output logic                   wr_accept,
    output logic                   buf_busy,
    output logic                   flush_valid,
    output logic [DISK_WORD_W-1:0] flush_word,
    output logic [31:0]            flush_data,
    output logic [3:0]             flush_be,
    output logic                   overflow_err
);

    localparam int unsigned TW = $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(FLUSH_TIMEOUT - 1);

    logic [31:0]            wbuf;
    logic [3:0]             wbe;
    logic [DISK_WORD_W-1:0] wtag;
    logic [TW-1:0]          idle_cnt;

    logic [3:0]  lane_bit;
    logic [31:0] fresh_data;
    logic [31:0] merged_data;
    logic        same_word;
    logic        flush_free;
    logic        do_merge;
    logic        do_swap;
    logic        do_drop;
    logic        timed_out;
    logic        do_drain;
    logic        load_flush;

    always_comb begin
        lane_bit   = 4'b0001 << wr_lane;
        fresh_data = '0;
        fresh_data[{wr_lane, 3'b000} +: 8] = wr_byte;
        // Stale lanes from an older word are discarded when a new word starts.
        merged_data = (wbe == '0) ? '0 : wbuf;
        merged_data[{wr_lane, 3'b000} +: 8] = wr_byte;

        same_word  = (wbe == '0) || (wtag == wr_word);
        // A flush register being drained this cycle can be refilled in the same cycle.
        flush_free = !flush_valid || flush_done;
        do_merge   = wr_en && same_word;
        do_swap    = wr_en && !same_word && flush_free;
        do_drop    = wr_en && !same_word && !flush_free;
        timed_out  = (wbe != '0) && (idle_cnt == TIMEOUT_LAST);
        do_drain   = !wr_en && (wbe != '0) && flush_free &&
                     ((wbe == 4'hF) || timed_out || force_flush);
        load_flush = do_swap || do_drain;
        wr_accept  = do_merge || do_swap;
        buf_busy   = (wbe != '0);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wbuf <= '0;
            wbe  <= '0;
            wtag <= '0;
        end else if (do_merge) begin
            wbuf <= merged_data;
            wbe  <= wbe | lane_bit;
            wtag <= wr_word;
        end else if (do_swap) begin
            wbuf <= fresh_data;
            wbe  <= lane_bit;
            wtag <= wr_word;
        end else if (do_drain) begin
            wbe <= '0;
        end
    end

    // Counts idle cycles since the last write while bytes are buffered;
    // saturates at the last value so a blocked flush fires once the register frees up.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idle_cnt <= '0;
        end else if (wr_en || (wbe == '0)) begin
            idle_cnt <= '0;
        end else if (!timed_out) begin
            idle_cnt <= idle_cnt + TW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush_valid <= 1'b0;
            flush_word  <= '0;
            flush_data  <= '0;
            flush_be    <= '0;
        end else if (load_flush) begin
            flush_valid <= 1'b1;
            flush_word  <= wtag;
            flush_data  <= wbuf;
            flush_be    <= wbe;
        end else if (flush_done) begin
            flush_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_err <= 1'b0;
        end else if (do_drop) begin
            overflow_err <= 1'b1;
        end
    end

endmodule

// File: rtl/usb_disk_mem_bridge.sv
// Bridges the byte-wide disk port of the USB mass-storage controller to a
// 32-bit word bus master. Writes are packed by usb_disk_wpack; reads are
// served from a one-word cache filled over the bus.
// Ports:
//   clk, rst      - system clock, asynchronous active-high reset
//   mem_addr      - disk byte address
//   mem_wen       - one-cycle write strobe for mem_wdata
//   mem_wdata     - write byte
//   mem_rdata     - registered read byte for mem_addr (00 when out of range)
//   bus_req       - bus request, held with bus_we/addr/wdata/be until bus_gnt
//   bus_we        - 1 = write, 0 = read
//   bus_addr      - bus word address (BASE_WORD + disk word, wrapping)
//   bus_wdata     - write word, lane k = byte 4n+k
//   bus_be        - write byte enables
//   bus_gnt       - request accepted
//   bus_rvalid    - read data valid
//   bus_rdata     - read word
//   busy          - buffered write, pending flush or bus transaction
//   overflow_err  - sticky: a write byte was dropped
module usb_disk_mem_bridge
    import usb_disk_pkg::*;
#(
    parameter longint unsigned DISK_BYTES    = 64'd33554432,
    parameter int unsigned     BASE_WORD     = 0,
    parameter int unsigned     ADDR_W        = 30,
    parameter int unsigned     FLUSH_TIMEOUT = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DISK_ADDR_W-1:0] mem_addr,
    input  logic                   mem_wen,
    input  logic [7:0]             mem_wdata,
    output logic [7:0]             mem_rdata,
    output logic                   bus_req,
    output logic                   bus_we,
    output logic [ADDR_W-1:0]      bus_addr,
    output logic [31:0]            bus_wdata,
    output logic [3:0]             bus_be,
    input  logic                   bus_gnt,
    input  logic                   bus_rvalid,
    input  logic [31:0]            bus_rdata,
    output logic                   busy,
    output logic                   overflow_err
);

    bridge_state_t state, state_nxt;

    logic [DISK_WORD_W-1:0] cur_word;
    logic [1:0]             cur_lane;
    logic                   in_range;
    logic                   wr_en;
    logic                   hit;
    logic                   miss;
    logic                   fill;
    logic                   coh_hit;

    logic                   cvalid;
    logic [DISK_WORD_W-1:0] ctag;
    logic [31:0]            cdata;
    logic [31:0]            cdata_nxt;
    logic [DISK_WORD_W-1:0] rd_word;

    logic                   wr_accept;
    logic                   buf_busy;
    logic                   flush_valid;
    logic [DISK_WORD_W-1:0] flush_word;
    logic [31:0]            flush_data;
    logic [3:0]             flush_be;
    logic                   flush_done;

    always_comb begin
        cur_word = mem_addr[DISK_ADDR_W-1:2];
        cur_lane = mem_addr[1:0];
        in_range = (64'(mem_addr) < DISK_BYTES);
        wr_en    = mem_wen && in_range;
        hit      = cvalid && (ctag == cur_word);
        miss     = in_range && !mem_wen && !hit;
        fill     = (state == RD_WAIT) && bus_rvalid;
        flush_done = (state == WR_REQ) && bus_gnt;
        // A write landing in the same cycle as a fill must patch the fresh data.
        coh_hit  = wr_accept && (fill ? (rd_word == cur_word) : hit);
    end

    usb_disk_wpack #(
        .FLUSH_TIMEOUT (FLUSH_TIMEOUT)
    ) u_wpack (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_word      (cur_word),
        .wr_lane      (cur_lane),
        .wr_byte      (mem_wdata),
        .force_flush  (miss),
        .flush_done   (flush_done),
        .wr_accept    (wr_accept),
        .buf_busy     (buf_busy),
        .flush_valid  (flush_valid),
        .flush_word   (flush_word),
        .flush_data   (flush_data),
        .flush_be     (flush_be),
        .overflow_err (overflow_err)
    );

    // FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM: next state; pending flushes win over reads so a read never
    // returns data older than a write already issued upstream.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (flush_valid) begin
                    state_nxt = WR_REQ;
                end else if (miss && !buf_busy) begin
                    state_nxt = RD_REQ;
                end
            end
            WR_REQ:  if (bus_gnt)    state_nxt = IDLE;
            RD_REQ:  if (bus_gnt)    state_nxt = RD_WAIT;
            RD_WAIT: if (bus_rvalid) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus_req   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        bus_be    = '0;
        unique case (state)
            WR_REQ: begin
                bus_req   = 1'b1;
                bus_we    = 1'b1;
                bus_addr  = ADDR_W'(BASE_WORD) + ADDR_W'(flush_word);
                bus_wdata = flush_data;
                bus_be    = flush_be;
            end
            RD_REQ: begin
                bus_req  = 1'b1;
                bus_addr = ADDR_W'(BASE_WORD) + ADDR_W'(rd_word);
            end
            default: ;
        endcase
        busy = buf_busy || flush_valid || (state != IDLE);
    end

    // Read target is captured on entry so the request stays stable until granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_word <= '0;
        end else if ((state == IDLE) && (state_nxt == RD_REQ)) begin
            rd_word <= cur_word;
        end
    end

    always_comb begin
        cdata_nxt = fill ? bus_rdata : cdata;
        if (coh_hit) begin
            cdata_nxt[{cur_lane, 3'b000} +: 8] = mem_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cvalid <= 1'b0;
            ctag   <= '0;
            cdata  <= '0;
        end else begin
            cdata <= cdata_nxt;
            if (fill) begin
                cvalid <= 1'b1;
                ctag   <= rd_word;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_rdata <= '0;
        end else if (!in_range) begin
            mem_rdata <= '0;
        end else if (hit) begin
            mem_rdata <= cdata[{cur_lane, 3'b000} +: 8];
        end
    end

endmodule

// File: tb/tb_usb_disk_mem_bridge.sv
module tb_usb_disk_mem_bridge;

    localparam logic [40:0] DISK = 41'h200_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [40:0] mem_addr;
    logic        mem_wen;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        bus_req;
    logic        bus_we;
    logic [29:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;
    logic        busy;
    logic        overflow_err;

    always #5 clk = ~clk;

    usb_disk_mem_bridge #(
        .DISK_BYTES    (64'd33554432),
        .BASE_WORD     (0),
        .ADDR_W        (30),
        .FLUSH_TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_addr     (mem_addr),
        .mem_wen      (mem_wen),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_be       (bus_be),
        .bus_gnt      (bus_gnt),
        .bus_rvalid   (bus_rvalid),
        .bus_rdata    (bus_rdata),
        .busy         (busy),
        .overflow_err (overflow_err)
    );

    typedef struct {
        logic        we;
        logic [29:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } txn_t;

    txn_t        exp_q[$];
    logic [7:0]  rd_q[$];
    bit [31:0]   mem [int unsigned];
    int          vectors = 0;
    int          miscompares = 0;
    logic        gnt_en;
    logic        rd_strobe;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] be_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            if (be[k]) m[k*8 +: 8] = 8'hFF;
        end
        return m;
    endfunction

    // Monitor: compares every accepted bus transaction and every sampled read byte.
    initial begin
        txn_t       t;
        logic [7:0] e;
        forever begin
            @(negedge clk);
            if (bus_req === 1'b1 && bus_gnt === 1'b1) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_txn: we=%0d addr=0x%08h wdata=0x%08h be=%h, expected none",
                             bus_we, bus_addr, bus_wdata, bus_be);
                end else begin
                    t = exp_q.pop_front();
                    check("bus_we", 32'(bus_we), 32'(t.we));
                    check("bus_addr", 32'(bus_addr), 32'(t.addr));
                    if (t.we) begin
                        check("bus_be", 32'(bus_be), 32'(t.be));
                        check("bus_wdata", bus_wdata & be_mask(t.be), t.wdata & be_mask(t.be));
                    end
                end
            end
            if (rd_strobe) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_queue: got 0x%02h, expected an entry", mem_rdata);
                end else begin
                    e = rd_q.pop_front();
                    check("mem_rdata", 32'(mem_rdata), 32'(e));
                end
            end
        end
    end

    // Bus slave: grants while enabled, applies writes to its memory,
    // returns read data 3 cycles after the grant.
    initial begin
        int          cnt;
        logic        gp;
        logic        g_we;
        logic [29:0] g_addr;
        logic [31:0] g_wdata;
        logic [3:0]  g_be;
        bit [31:0]   old;
        cnt = 0; gp = 0; g_we = 0; g_addr = '0; g_wdata = '0; g_be = '0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = '0;
        forever begin
            @(posedge clk);
            #2;
            bus_rvalid = 0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 1) begin
                    bus_rvalid = 1;
                    bus_rdata  = mem.exists(int'(g_addr)) ? mem[int'(g_addr)] : 32'h0;
                end
            end
            if (gp) begin
                if (g_we) begin
                    old = mem.exists(int'(g_addr)) ? mem[int'(g_addr)] : 32'h0;
                    mem[int'(g_addr)] = (old & ~be_mask(g_be)) | (g_wdata & be_mask(g_be));
                end else begin
                    cnt = 3;
                end
            end
            gp = 0;
            bus_gnt = bus_req && gnt_en && !rst;
            if (bus_gnt) begin
                gp = 1; g_we = bus_we; g_addr = bus_addr; g_wdata = bus_wdata; g_be = bus_be;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [40:0] a, input logic [7:0] d);
        mem_addr = a; mem_wdata = d; mem_wen = 1;
        tick();
        mem_wen = 0; mem_addr = DISK;
    endtask

    task automatic rd(input logic [40:0] a, input logic [7:0] e);
        mem_addr = a;
        idle(40);
        rd_q.push_back(e);
        rd_strobe = 1;
        tick();
        rd_strobe = 0;
    endtask

    task automatic push_w(input logic [29:0] a, input logic [31:0] d, input logic [3:0] be);
        txn_t t;
        t.we = 1; t.addr = a; t.wdata = d; t.be = be;
        exp_q.push_back(t);
    endtask

    task automatic push_r(input logic [29:0] a);
        txn_t t;
        t.we = 0; t.addr = a; t.wdata = '0; t.be = '0;
        exp_q.push_back(t);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            tick();
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1; mem_addr = DISK; mem_wen = 0; mem_wdata = '0;
        gnt_en = 1; rd_strobe = 0;
        idle(3);
        check("rst_bus_req", 32'(bus_req), 32'd0);
        check("rst_bus_we", 32'(bus_we), 32'd0);
        check("rst_bus_be", 32'(bus_be), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overflow", 32'(overflow_err), 32'd0);
        check("rst_rdata", 32'(mem_rdata), 32'd0);
        rst = 0;
        idle(2);

        // Full word packing
        push_w(30'h80, 32'h0302_0100, 4'hF);
        for (int i = 0; i < 4; i++) begin
            wr(41'h200 + 41'(i), 8'(i));
            idle(39);
        end
        drain("t1_drain");

        // Word change flushes the partial word; the new byte times out later
        push_w(30'h1, 32'h0000_AA00, 4'h2);
        push_w(30'h3, 32'h0000_00BB, 4'h1);
        wr(41'd5, 8'hAA);
        idle(39);
        wr(41'd12, 8'hBB);
        idle(30);
        check("t2_buffered_busy", 32'(busy), 32'd1);
        check("t2_no_early_flush", 32'(exp_q.size()), 32'd1);
        drain("t2_drain");

        // One bus read serves four bytes
        mem[32'h10] = 32'hDDCC_BBAA;
        push_r(30'h10);
        rd(41'h40, 8'hAA);
        rd(41'h41, 8'hBB);
        rd(41'h42, 8'hCC);
        rd(41'h43, 8'hDD);
        mem_addr = DISK;
        drain("t3_drain");

        // Read after partial write: flush first, then read; then coherent update
        push_w(30'h40, 32'h0000_5A00, 4'h2);
        push_r(30'h40);
        wr(41'h101, 8'h5A);
        rd(41'h101, 8'h5A);
        push_w(30'h40, 32'h0077_0000, 4'h4);
        wr(41'h102, 8'h77);
        rd(41'h102, 8'h77);
        mem_addr = DISK;
        drain("t4_drain");

        // Flush register blocked: third word byte dropped
        gnt_en = 0;
        push_w(30'h100, 32'h0000_0011, 4'h1);
        push_w(30'h101, 32'h0000_2200, 4'h2);
        wr(41'h400, 8'h11);
        idle(5);
        wr(41'h405, 8'h22);
        idle(5);
        check("t5_overflow_before", 32'(overflow_err), 32'd0);
        wr(41'h40A, 8'h33);
        idle(1);
        check("t5_overflow_set", 32'(overflow_err), 32'd1);
        check("t5_req_held", 32'(bus_req), 32'd1);
        gnt_en = 1;
        drain("t5_drain");
        check("t5_overflow_sticky", 32'(overflow_err), 32'd1);

        // Out of range: ignored writes, zero read data, no bus traffic
        rd(41'h102, 8'h77);
        wr(DISK, 8'h99);
        idle(2);
        check("t6_oor_wr_busy", 32'(busy), 32'd0);
        rd(DISK, 8'h00);
        rd(41'h100_0000_0000, 8'h00);
        check("t6_oor_busy", 32'(busy), 32'd0);

        // Last in-range byte
        mem[32'h7F_FFFF] = 32'h1234_5678;
        push_r(30'h7F_FFFF);
        rd(DISK - 41'd1, 8'h12);
        mem_addr = DISK;
        drain("t6_last_drain");

        // Reset during RD_WAIT
        push_r(30'h200);
        mem_addr = 41'h800;
        n = 0;
        while (!(bus_req === 1'b1 && bus_gnt === 1'b1) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("t7_grant_seen", 32'(n < 100), 32'd1);
        tick();
        check("t7_rd_wait_busy", 32'(busy), 32'd1);
        rst = 1;
        #1;
        check("t7_rst_bus_req", 32'(bus_req), 32'd0);
        check("t7_rst_busy", 32'(busy), 32'd0);
        mem_addr = DISK;
        idle(2);
        rst = 0;
        idle(5);
        check("t7_overflow_cleared", 32'(overflow_err), 32'd0);
        check("t7_rdata_cleared", 32'(mem_rdata), 32'd0);
        // Cache was invalidated: the same word must be fetched again
        push_r(30'h10);
        rd(41'h43, 8'hDD);
        mem_addr = DISK;
        drain("t7_drain");

        idle(5);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
